// File: rtl/csr_file_ext_if.sv
// CSR access bus between the decode/execute stage (master) and the machine-mode CSR file (slave).
interface csr_file_ext_if;
  logic        csr_ren;
  logic        csr_wen;
  logic [11:0] csr_rwaddr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        csr_illegal;

  modport master (output csr_ren, csr_wen, csr_rwaddr, csr_wdata,
                  input  csr_rdata, csr_illegal);
  modport slave  (input  csr_ren, csr_wen, csr_rwaddr, csr_wdata,
                  output csr_rdata, csr_illegal);
endinterface

// File: rtl/csr_file_ext.sv
// Machine-mode CSR file with local interrupts, mtval, mcountinhibit, writable 64-bit counters
// and illegal-access detection; sits between CSR instruction execute and the trap controller.
module csr_file_ext #(
  parameter int unsigned PC_LEN        = 30,
  parameter int unsigned NUM_LOCAL_INT = 4,
  parameter int unsigned NUM_HPM       = 2,
  parameter int unsigned CNT_WIDTH     = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       stall_n,
  input  logic                       instruction_retire,
  input  logic [NUM_HPM-1:0]         hpm_event,
  csr_file_ext_if.slave              bus,
  output logic [31:0]                csr_mstatus,
  output logic [2+NUM_LOCAL_INT:0]   csr_mie,
  output logic [2+NUM_LOCAL_INT:0]   csr_mip,
  output logic [31:0]                csr_mtvec,
  output logic [PC_LEN-1:0]          csr_mepc,
  input  logic                       trap_occurred,
  input  logic                       trap_returned,
  input  logic [PC_LEN-1:0]          new_mepc,
  input  logic [31:0]                new_mcause,
  input  logic [31:0]                new_mtval,
  input  logic                       mextern_int,
  input  logic                       mtimer_int,
  input  logic                       msoftware_int,
  input  logic [NUM_LOCAL_INT-1:0]   local_int
);
  localparam int unsigned PC_ZEROS = 32 - PC_LEN;
  localparam int unsigned IRQ_W    = 3 + NUM_LOCAL_INT;
  localparam int unsigned NCNT     = 3 + NUM_HPM;
  localparam int unsigned CW       = CNT_WIDTH;
  localparam logic [NCNT-1:0] MINH_MASK = ~(NCNT'(2));

  logic              r_st_mie, r_st_mpie;
  logic [IRQ_W-1:0]  r_mie;
  logic [31:0]       r_mtvec;
  logic [NCNT-1:0]   r_minh;
  logic [CW-1:0]     r_cnt [NCNT];
  logic [31:0]       r_mscratch, r_mcause, r_mtval;
  logic [PC_LEN-1:0] r_mepc;

  logic [11:0]      w_addr;
  logic [31:0]      w_wdata, w_mstatus, w_rdata;
  logic             w_wr, w_ro, w_impl, w_cnt_hit, w_cnt_wr, w_cnt_hi;
  logic [4:0]       w_cnt_idx;
  logic [CW-1:0]    w_cnt_sel;
  logic [63:0]      w_cnt_ext;
  logic [NCNT-1:0]  w_inc;
  logic [IRQ_W-1:0] w_mip, w_mie_wr;

  // Spread the compact {local, MEIE, MTIE, MSIE} layout onto CSR bit positions.
  function automatic logic [31:0] irq_to_csr(input logic [IRQ_W-1:0] v);
    logic [31:0] d;
    d     = '0;
    d[3]  = v[0];
    d[7]  = v[1];
    d[11] = v[2];
    for (int unsigned i = 0; i < NUM_LOCAL_INT; i++) d[16+i] = v[3+i];
    return d;
  endfunction

  assign w_addr    = bus.csr_rwaddr;
  assign w_wdata   = bus.csr_wdata;
  assign w_wr      = bus.csr_wen & stall_n & (w_addr[11:10] != 2'b11);
  assign w_ro      = (w_addr[11:10] == 2'b11) | (w_addr == 12'h342) | (w_addr == 12'h344);
  assign w_mip     = {local_int, mextern_int, mtimer_int, msoftware_int};
  assign w_mstatus = {19'b0, 2'b11, 3'b0, r_st_mpie, 3'b0, r_st_mie, 3'b0};

  // Counter window: 0xB00-0xB1F/0xB80-0xB9F writable, 0xCxx mirrors; slot 1 (time) absent.
  assign w_cnt_idx = w_addr[4:0];
  assign w_cnt_hi  = w_addr[7];
  assign w_cnt_hit = ((w_addr[11:8] == 4'hB) | (w_addr[11:8] == 4'hC)) & (w_addr[6:5] == 2'b00)
                   & (32'(w_cnt_idx) < NCNT) & (w_cnt_idx != 5'd1);
  assign w_cnt_wr  = w_wr & w_cnt_hit;
  assign w_cnt_ext = 64'(w_cnt_sel);

  always_comb begin
    w_cnt_sel = '0;
    for (int unsigned i = 0; i < NCNT; i++)
      if (w_cnt_idx == 5'(i)) w_cnt_sel = r_cnt[i];
  end

  always_comb begin
    w_inc    = '0;
    w_inc[0] = 1'b1;
    w_inc[2] = instruction_retire;
    for (int unsigned i = 0; i < NUM_HPM; i++) w_inc[3+i] = hpm_event[i];
  end

  always_comb begin
    w_mie_wr    = '0;
    w_mie_wr[0] = w_wdata[3];
    w_mie_wr[1] = w_wdata[7];
    w_mie_wr[2] = w_wdata[11];
    for (int unsigned i = 0; i < NUM_LOCAL_INT; i++) w_mie_wr[3+i] = w_wdata[16+i];
  end

  always_comb begin
    w_rdata = '0;
    w_impl  = 1'b1;
    case (w_addr)
      12'h300: w_rdata = w_mstatus;
      12'h304: w_rdata = irq_to_csr(r_mie);
      12'h305: w_rdata = r_mtvec;
      12'h320: w_rdata = 32'(r_minh);
      12'h340: w_rdata = r_mscratch;
      12'h341: w_rdata = 32'(r_mepc) << PC_ZEROS;
      12'h342: w_rdata = r_mcause;
      12'h343: w_rdata = r_mtval;
      12'h344: w_rdata = irq_to_csr(w_mip);
      12'hF14: w_rdata = '0;
      default: begin
        if (w_cnt_hit) w_rdata = w_cnt_hi ? w_cnt_ext[63:32] : w_cnt_ext[31:0];
        else           w_impl  = 1'b0;
      end
    endcase
  end

  assign bus.csr_rdata   = w_rdata;
  assign bus.csr_illegal = ((bus.csr_ren | bus.csr_wen) & ~w_impl) | (bus.csr_wen & w_ro);

  // Reset-valued state: status, enables, vector, inhibit and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_st_mie  <= 1'b0;
      r_st_mpie <= 1'b0;
      r_mie     <= '0;
      r_mtvec   <= '0;
      r_minh    <= '0;
      for (int unsigned i = 0; i < NCNT; i++) r_cnt[i] <= '0;
    end else begin
      if (w_wr) begin
        case (w_addr)
          12'h300: begin
            r_st_mie  <= w_wdata[3];
            r_st_mpie <= w_wdata[7];
          end
          12'h304: r_mie   <= w_mie_wr;
          12'h305: r_mtvec <= {w_wdata[31:2], w_wdata[1] ? 2'b00 : w_wdata[1:0]};
          12'h320: r_minh  <= w_wdata[NCNT-1:0] & MINH_MASK;
          default: ;
        endcase
      end else if (trap_occurred) begin
        r_st_mpie <= r_st_mie;
        r_st_mie  <= 1'b0;
      end else if (trap_returned) begin
        r_st_mie  <= r_st_mpie;
        r_st_mpie <= 1'b1;
      end
      // Inhibit is sampled before this cycle's write lands, so a new value applies next cycle.
      for (int unsigned i = 0; i < NCNT; i++) begin
        if (w_cnt_wr && (w_cnt_idx == 5'(i))) begin
          if (w_cnt_hi) r_cnt[i] <= {w_wdata[CW-33:0], r_cnt[i][31:0]};
          else          r_cnt[i] <= {r_cnt[i][CW-1:32], w_wdata};
        end else if (w_inc[i] && !r_minh[i]) begin
          r_cnt[i] <= r_cnt[i] + CW'(1);
        end
      end
    end
  end

  // Scratch and trap-capture registers carry no reset value.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      case (w_addr)
        12'h340: r_mscratch <= w_wdata;
        12'h341: r_mepc     <= w_wdata[31:PC_ZEROS];
        12'h343: r_mtval    <= w_wdata;
        default: ;
      endcase
    end else if (trap_occurred) begin
      r_mepc   <= new_mepc;
      r_mcause <= new_mcause;
      r_mtval  <= new_mtval;
    end
  end

  assign csr_mstatus = w_mstatus;
  assign csr_mie     = r_mie;
  assign csr_mip     = w_mip;
  assign csr_mtvec   = r_mtvec;
  assign csr_mepc    = r_mepc;
endmodule
